// File: rtl/io_key_in_if.sv
// dma_io bus bundle shared by io_key_in and whatever drives the CPU side.
// Latency: n/a (wires only). Backpressure: none; a write is a one-cycle strobe.
// Signals: we/wadr/wdata (write port), radr/rdata_in (read address and upstream chain data), rdata (chain output).
interface io_key_in_if;
  logic        we;
  logic [13:0] wadr;
  logic [15:0] wdata;
  logic [13:0] radr;
  logic [15:0] rdata_in;
  logic [15:0] rdata;

  modport master (output we, wadr, wdata, radr, rdata_in, input rdata);
  modport slave  (input we, wadr, wdata, radr, rdata_in, output rdata);
endinterface

// File: rtl/io_key_in.sv
// Key input responder: 2-FF sync, per-key debounce, sticky W1C edge capture, level IRQ, dma_io read chain member.
// Latency: key_in to LEVEL 2+DB_CYCLES cycles, EDGE one cycle later, key_irq one more; reads return one cycle after radr.
// Backpressure: none; writes are single-cycle strobes and reads are always answered (own data on hit, else upstream data).
// Ports: clk, rst_n (synchronous, active-HIGH despite the name), key_in[KEY_NUM], dma_io (slave modport), key_irq.
// Build option: define IO_KEY_DB_BYPASS_EN to drop the debounce counters (debounced = synchronized level).
module io_key_in #(
  parameter int              KEY_NUM   = 4,
  parameter int              DB_W      = 16,
  parameter logic [DB_W-1:0] DB_CYCLES = 16'd50000,
  parameter logic [13:0]     BASE_ADR  = 14'h3FF8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [KEY_NUM-1:0] key_in,
  io_key_in_if.slave         dma_io,
  output logic               key_irq
);

  logic [KEY_NUM-1:0] sync1, sync2;
  logic [KEY_NUM-1:0] db, db_d;
  logic [KEY_NUM-1:0] edge_q, irq_en;
  logic [1:0]         ctrl;

  logic               wr_hit, rd_hit;
  logic [KEY_NUM-1:0] rise, fall, edge_set, edge_clr;
  logic [15:0]        rd_val;

  // Two-stage synchronizer; stage outputs are only used after sync2.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

`ifdef IO_KEY_DB_BYPASS_EN
  assign db = sync2;
`else
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DB_CYCLES - 1);

  logic [DB_W-1:0] cnt [KEY_NUM];

  // The counter only runs while the synced level disagrees with the accepted
  // level, so any return to agreement (a glitch) restarts the whole window.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      db <= '0;
      for (int i = 0; i < KEY_NUM; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < KEY_NUM; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end
`endif

  assign wr_hit = dma_io.we && (dma_io.wadr[13:2] == BASE_ADR[13:2]);
  assign rd_hit = (dma_io.radr[13:2] == BASE_ADR[13:2]);

  assign rise     = db & ~db_d;
  assign fall     = ~db & db_d;
  assign edge_set = (rise & {KEY_NUM{ctrl[0]}}) | (fall & {KEY_NUM{ctrl[1]}});
  assign edge_clr = (wr_hit && dma_io.wadr[1:0] == 2'd1) ? dma_io.wdata[KEY_NUM-1:0] : '0;

  always_comb begin
    rd_val = '0;
    case (dma_io.radr[1:0])
      2'd0:    rd_val[KEY_NUM-1:0] = db;
      2'd1:    rd_val[KEY_NUM-1:0] = edge_q;
      2'd2:    rd_val[KEY_NUM-1:0] = irq_en;
      default: rd_val[1:0]         = ctrl;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      db_d         <= '0;
      edge_q       <= '0;
      irq_en       <= '0;
      ctrl         <= 2'b01;
      key_irq      <= 1'b0;
      dma_io.rdata <= '0;
    end else begin
      db_d   <= db;
      // Clear is applied first so a same-cycle capture survives the W1C.
      edge_q <= (edge_q & ~edge_clr) | edge_set;
      if (wr_hit && dma_io.wadr[1:0] == 2'd2) irq_en <= dma_io.wdata[KEY_NUM-1:0];
      if (wr_hit && dma_io.wadr[1:0] == 2'd3) ctrl   <= dma_io.wdata[1:0];
      key_irq <= |(edge_q & irq_en);
      // Misses are registered too so every chain member has the same latency.
      dma_io.rdata <= rd_hit ? rd_val : dma_io.rdata_in;
    end
  end

endmodule

// File: tb/tb_io_key_in.sv
module tb_io_key_in;
  localparam int          KN   = 4;
  localparam int          DB   = 4;
  localparam logic [13:0] BASE = 14'h3FF8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [KN-1:0] key_in;
  logic          key_irq;

  io_key_in_if bus();

  io_key_in #(.KEY_NUM(KN), .DB_W(16), .DB_CYCLES(16'd4), .BASE_ADR(BASE)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .key_in (key_in),
    .dma_io (bus.slave),
    .key_irq(key_irq)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounce rule: a key's accepted level flips when the synchronized level
  // (key_in delayed two edges) has differed from it for the last DB samples.
  logic [KN-1:0] kq[$];
  logic [KN-1:0] m_db, m_rise, m_fall, m_edge, m_en, nd, m_set, m_clr;
  logic [1:0]    m_ctrl;
  logic          m_irq;
  logic [15:0]   m_rdata, rv;
  bit            m_valid = 0;
  bit            all_diff;
  logic          hw;

  always @(posedge clk) begin
    if (rst_n) begin
      kq.delete();
      repeat (DB + 2) kq.push_back('0);
      m_db = '0; m_rise = '0; m_fall = '0; m_edge = '0; m_en = '0;
      m_ctrl = 2'b01; m_irq = 1'b0; m_rdata = '0; m_valid = 1;
    end else if (m_valid) begin
      rv = 16'h0;
      if (bus.radr[13:2] == BASE[13:2]) begin
        case (bus.radr[1:0])
          2'd0: rv = 16'(m_db);
          2'd1: rv = 16'(m_edge);
          2'd2: rv = 16'(m_en);
          default: rv = 16'(m_ctrl);
        endcase
      end else begin
        rv = bus.rdata_in;
      end
      hw    = bus.we && (bus.wadr[13:2] == BASE[13:2]);
      m_irq = |(m_edge & m_en);
      m_set = (m_rise & {KN{m_ctrl[0]}}) | (m_fall & {KN{m_ctrl[1]}});
      m_clr = (hw && bus.wadr[1:0] == 2'd1) ? bus.wdata[KN-1:0] : '0;
      m_edge = (m_edge & ~m_clr) | m_set;
      if (hw && bus.wadr[1:0] == 2'd2) m_en   = bus.wdata[KN-1:0];
      if (hw && bus.wadr[1:0] == 2'd3) m_ctrl = bus.wdata[1:0];
      nd = m_db;
      for (int i = 0; i < KN; i++) begin
        all_diff = 1;
        for (int j = 2; j <= DB + 1; j++)
          if (kq[kq.size() - j][i] == m_db[i]) all_diff = 0;
        if (all_diff) nd[i] = ~m_db[i];
      end
      m_rise  = nd & ~m_db;
      m_fall  = ~nd & m_db;
      m_db    = nd;
      m_rdata = rv;
      kq.push_back(key_in);
      void'(kq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("mdl_rdata", {16'h0, bus.rdata}, {16'h0, m_rdata});
      chk("mdl_irq", {31'h0, key_irq}, {31'h0, m_irq});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0; bus.wadr = '0; bus.wdata = '0; bus.rdata_in = '0;
  endtask

  task automatic wr(input logic [13:0] adr, input logic [15:0] d);
    bus.we = 1'b1; bus.wadr = adr; bus.wdata = d;
    tick();
    bus.we = 1'b0;
  endtask

  task automatic rd(input logic [13:0] adr, input logic [15:0] exp, input string name);
    bus.radr = adr;
    tick();
    chk(name, {16'h0, bus.rdata}, {16'h0, exp});
  endtask

  typedef struct {
    logic        we;
    logic [13:0] wadr;
    logic [15:0] wdata;
    logic [13:0] radr;
    logic [15:0] rin;
    logic [15:0] exp;
  } vec_t;

  vec_t vt[15];
  int   hold;

  initial begin
    rst_n = 1'b1; key_in = '0; bus.radr = '0; idle();

    vt[0]  = '{1'b0, 14'h0000, 16'h0000, 14'h3FF8, 16'h5A5A, 16'h0000};
    vt[1]  = '{1'b0, 14'h0000, 16'h0000, 14'h3FF9, 16'h5A5A, 16'h0000};
    vt[2]  = '{1'b0, 14'h0000, 16'h0000, 14'h3FFA, 16'h5A5A, 16'h0000};
    vt[3]  = '{1'b0, 14'h0000, 16'h0000, 14'h3FFB, 16'h5A5A, 16'h0001};
    vt[4]  = '{1'b0, 14'h0000, 16'h0000, 14'h0010, 16'hA5A5, 16'hA5A5};
    vt[5]  = '{1'b1, 14'h3FFA, 16'hFFFF, 14'h3FFA, 16'h5A5A, 16'h0000};
    vt[6]  = '{1'b0, 14'h0000, 16'h0000, 14'h3FFA, 16'h5A5A, 16'h000F};
    vt[7]  = '{1'b1, 14'h3FFB, 16'hFFFF, 14'h3FFB, 16'h5A5A, 16'h0001};
    vt[8]  = '{1'b0, 14'h0000, 16'h0000, 14'h3FFB, 16'h5A5A, 16'h0003};
    vt[9]  = '{1'b1, 14'h3FF8, 16'hFFFF, 14'h3FF8, 16'h5A5A, 16'h0000};
    vt[10] = '{1'b1, 14'h3FFE, 16'h0000, 14'h3FFA, 16'h5A5A, 16'h000F};
    vt[11] = '{1'b0, 14'h0000, 16'h0000, 14'h3FF4, 16'h1234, 16'h1234};
    vt[12] = '{1'b1, 14'h3FFA, 16'h0000, 14'h3FFB, 16'h5A5A, 16'h0003};
    vt[13] = '{1'b1, 14'h3FFB, 16'h0001, 14'h3FFA, 16'h5A5A, 16'h0000};
    vt[14] = '{1'b0, 14'h0000, 16'h0000, 14'h3FFB, 16'h5A5A, 16'h0001};

    tick(); tick();
    rst_n = 1'b0;
    chk("reset_rdata", {16'h0, bus.rdata}, 32'h0);
    chk("reset_irq", {31'h0, key_irq}, 32'h0);

    // Register access table (reset values, masking, pre-write reads, chain pass-through).
    for (int v = 0; v < 15; v++) begin
      bus.we = vt[v].we; bus.wadr = vt[v].wadr; bus.wdata = vt[v].wdata;
      bus.radr = vt[v].radr; bus.rdata_in = vt[v].rin;
      tick();
      chk($sformatf("vec%0d_rdata", v), {16'h0, bus.rdata}, {16'h0, vt[v].exp});
      chk($sformatf("vec%0d_irq", v), {31'h0, key_irq}, 32'h0);
    end
    idle();

    // Glitch shorter than the debounce window.
    key_in = 4'b0001;
    repeat (3) tick();
    key_in = 4'b0000;
    repeat (10) tick();
    rd(BASE + 0, 16'h0000, "glitch_level");
    rd(BASE + 1, 16'h0000, "glitch_edge");

    // Held press: LEVEL changes at edge 2+DB, visible on rdata one edge later.
    key_in = 4'b0001; bus.radr = BASE;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k >= 5) chk($sformatf("hold_level_e%0d", k), {16'h0, bus.rdata}, (k >= 7) ? 32'h1 : 32'h0);
    end
    rd(BASE + 1, 16'h0001, "hold_edge");

    // Interrupt assert/deassert timing.
    key_in = 4'b0000;
    repeat (8) tick();
    wr(BASE + 1, 16'h0001);
    wr(BASE + 2, 16'h0001);
    chk("irq_idle", {31'h0, key_irq}, 32'h0);
    key_in = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k >= 7) chk($sformatf("irq_e%0d", k), {31'h0, key_irq}, (k >= 8) ? 32'h1 : 32'h0);
    end
    wr(BASE + 1, 16'h0001);
    chk("irq_after_clr_w", {31'h0, key_irq}, 32'h1);
    tick();
    chk("irq_after_clr_w1", {31'h0, key_irq}, 32'h0);
    rd(BASE + 1, 16'h0000, "edge_cleared");

    // Fall-only capture.
    wr(BASE + 2, 16'h0000);
    key_in = 4'b0000;
    repeat (8) tick();
    wr(BASE + 3, 16'h0002);
    rd(BASE + 1, 16'h0000, "fall_release0");
    key_in = 4'b0100;
    repeat (8) tick();
    rd(BASE + 1, 16'h0000, "fall_press2");
    key_in = 4'b0000;
    repeat (8) tick();
    rd(BASE + 1, 16'h0004, "fall_release2");

    // W1C colliding with a capture on the same bit: capture wins, other bit clears.
    wr(BASE + 3, 16'h0003);
    key_in = 4'b0010;
    repeat (6) tick();
    wr(BASE + 1, 16'h0006);
    rd(BASE + 1, 16'h0002, "w1c_vs_set");

    // Reset in the middle of a debounce count.
    key_in = 4'b0000;
    repeat (8) tick();
    key_in = 4'b0010;
    repeat (4) tick();
    rst_n = 1'b1;
    tick();
    rst_n = 1'b0;
    chk("midrst_rdata", {16'h0, bus.rdata}, 32'h0);
    chk("midrst_irq", {31'h0, key_irq}, 32'h0);
    bus.radr = BASE;
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("midrst_level_e%0d", k), {16'h0, bus.rdata}, (k >= 7) ? 32'h2 : 32'h0);
    end
    rd(BASE + 1, 16'h0002, "midrst_edge");
    rd(BASE + 2, 16'h0000, "midrst_en");
    rd(BASE + 3, 16'h0001, "midrst_ctrl");

    // Randomized traffic against the model.
    hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        key_in = KN'($urandom);
        hold   = $urandom_range(1, 7);
      end
      hold--;
      rst_n        = ($urandom_range(0, 299) == 0);
      bus.we       = ($urandom_range(0, 3) == 0);
      bus.wadr     = BASE - 14'd1 + 14'($urandom_range(0, 5));
      bus.wdata    = 16'($urandom);
      bus.radr     = BASE - 14'd1 + 14'($urandom_range(0, 5));
      bus.rdata_in = 16'($urandom);
      tick();
    end
    rst_n = 1'b0;
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
